// File: rtl/uart_wb_bridge_if.sv
// rtl/uart_wb_bridge_if.sv - signal bundle between uart_wb_bridge and its UART / Wishbone neighbours
//  rx_data/rx_valid            received byte strobe from the UART receiver
//  tx_data/tx_valid/tx_ready   response byte handshake toward the UART transmitter
//  wb_*                        8-bit Wishbone classic master signals
//  busy/err                    status: bus or response phase active / one-cycle error pulse
interface uart_wb_bridge_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [7:0]        wb_dat_o;
  logic [7:0]        wb_dat_i;
  logic              wb_ack_i;
  logic              busy;
  logic              err;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    output tx_data, tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, busy, err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    input  tx_data, tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, busy, err
  );
endinterface

// File: rtl/uart_wb_bridge.sv
// rtl/uart_wb_bridge.sv - UART byte command decoder running one Wishbone classic cycle per frame
//  clk   system clock, posedge
//  nrst  asynchronous active-low reset
//  bus   uart_wb_bridge_if.master: rx byte in, response byte out, Wishbone master, busy/err
//  Frames: 'W' addr data -> write, response 'K'; 'R' addr -> read, response is read data.
//  Ack timeout answers 'E'. ADDR_W must match the interface instance.
module uart_wb_bridge #(
  parameter int ADDR_W   = 8,
  parameter int FRAME_TO = 100000,
  parameter int ACK_TO   = 1024
) (
  input  logic              clk,
  input  logic              nrst,
  uart_wb_bridge_if.master  bus
);

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam int FTW = $clog2(FRAME_TO + 1);
  localparam int ATW = $clog2(ACK_TO + 1);

  typedef enum logic [2:0] {S_OP, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t            state, state_nx;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [7:0]        dat_q;
  logic [7:0]        rsp_q;
  logic [FTW-1:0]    ftmr;
  logic [ATW-1:0]    acnt;
  logic              err_q;

  logic in_frame, is_op, bad_op, frame_tmo, ack_tmo, overrun;

  always_comb begin
    in_frame  = (state == S_ADDR) || (state == S_DATA);
    is_op     = (bus.rx_data == OP_W) || (bus.rx_data == OP_R);
    bad_op    = (state == S_OP) && bus.rx_valid && !is_op;
    // A byte arriving on the expiry cycle wins over the timeout.
    frame_tmo = in_frame && !bus.rx_valid && (ftmr == FTW'(FRAME_TO - 1));
    // An ack on the expiry cycle wins over the timeout.
    ack_tmo   = (state == S_BUS) && !bus.wb_ack_i && (acnt == ATW'(ACK_TO - 1));
    overrun   = ((state == S_BUS) || (state == S_RESP)) && bus.rx_valid;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_OP;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_OP:    if (bus.rx_valid && is_op) state_nx = S_ADDR;
      S_ADDR:  if (bus.rx_valid)      state_nx = we_q ? S_DATA : S_BUS;
               else if (frame_tmo)    state_nx = S_OP;
      S_DATA:  if (bus.rx_valid)      state_nx = S_BUS;
               else if (frame_tmo)    state_nx = S_OP;
      S_BUS:   if (bus.wb_ack_i || ack_tmo) state_nx = S_RESP;
      S_RESP:  if (bus.tx_ready)      state_nx = S_OP;
      default: state_nx = S_OP;
    endcase
  end

  // Bus and response outputs are pure state decodes so an async reset drops them at once.
  always_comb begin
    bus.wb_cyc_o = (state == S_BUS);
    bus.wb_stb_o = (state == S_BUS);
    bus.wb_we_o  = we_q;
    bus.wb_adr_o = adr_q;
    bus.wb_dat_o = dat_q;
    bus.tx_valid = (state == S_RESP);
    bus.tx_data  = rsp_q;
    bus.busy     = (state == S_BUS) || (state == S_RESP);
    bus.err      = err_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      rsp_q <= '0;
      ftmr  <= '0;
      acnt  <= '0;
      err_q <= 1'b0;
    end else begin
      // Coincident causes collapse into the same single-cycle pulse.
      err_q <= bad_op || frame_tmo || ack_tmo || overrun;

      if (state == S_OP && bus.rx_valid && is_op) we_q <= (bus.rx_data == OP_W);
      if (state == S_ADDR && bus.rx_valid) adr_q <= bus.rx_data[ADDR_W-1:0];
      if (state == S_DATA && bus.rx_valid) dat_q <= bus.rx_data;

      if (state == S_BUS) begin
        if (bus.wb_ack_i)  rsp_q <= we_q ? RSP_K : bus.wb_dat_i;
        else if (ack_tmo)  rsp_q <= RSP_E;
      end

      // Inter-byte timer: cleared by every accepted byte, counts only mid-frame, saturates.
      if (bus.rx_valid && (state == S_OP || in_frame)) ftmr <= '0;
      else if (in_frame && ftmr != FTW'(FRAME_TO))     ftmr <= ftmr + 1'b1;

      if (state != S_BUS)            acnt <= '0;
      else if (acnt != ATW'(ACK_TO)) acnt <= acnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb/tb_uart_wb_bridge.sv - self-checking bench for uart_wb_bridge
module tb_uart_wb_bridge;
  localparam int AW  = 6;
  localparam int FTO = 20;
  localparam int ATO = 16;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  uart_wb_bridge_if #(.ADDR_W(AW)) bus();
  uart_wb_bridge #(.ADDR_W(AW), .FRAME_TO(FTO), .ACK_TO(ATO)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { logic we; logic [7:0] adr; logic [7:0] dat; int len; } txn_t;
  txn_t       txn_q[$];
  txn_t       cur;
  logic [7:0] tx_q[$];
  logic [7:0] last_tx;
  bit         pend = 0;
  int         ack_delay = 1;   // 0 = slave never acks
  logic [7:0] rd_byte = 8'h00;
  bit         stray_en = 0;
  int         cyc_cnt = 0;
  int         err_cnt = 0;
  int         viol = 0;

  function automatic logic [7:0] exp_adr(input logic [7:0] a);
    return a % (1 << AW);
  endfunction

  function automatic logic [7:0] exp_rsp(input bit we, input int dly, input logic [7:0] rd);
    if (dly == 0) return 8'h45;
    return we ? 8'h4B : rd;
  endfunction

  // Wishbone slave model plus observers, all on the falling edge.
  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.err === 1'b1) err_cnt++;
      if (bus.wb_stb_o !== bus.wb_cyc_o) viol++;
      if (bus.busy !== (bus.wb_cyc_o | bus.tx_valid)) viol++;
      if (pend && bus.tx_valid && bus.tx_data !== last_tx) viol++;
      pend    = bus.tx_valid && !bus.tx_ready;
      last_tx = bus.tx_data;
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) tx_q.push_back(bus.tx_data);
      if (bus.wb_cyc_o === 1'b1) begin
        cyc_cnt++;
        if (cyc_cnt == 1) begin
          cur.we = bus.wb_we_o; cur.adr = 8'(bus.wb_adr_o); cur.dat = bus.wb_dat_o;
        end else if (cur.we !== bus.wb_we_o || cur.adr !== 8'(bus.wb_adr_o) || cur.dat !== bus.wb_dat_o) begin
          viol++;
        end
        bus.wb_ack_i = (ack_delay != 0 && cyc_cnt == ack_delay);
        bus.wb_dat_i = bus.wb_ack_i ? rd_byte : 8'($urandom);
      end else begin
        if (cyc_cnt != 0) begin cur.len = cyc_cnt; txn_q.push_back(cur); end
        cyc_cnt = 0;
        bus.wb_ack_i = stray_en ? 1'($urandom) : 1'b0;
        bus.wb_dat_i = 8'($urandom);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end, got timeout exp finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Byte is presented during the k-th cycle after the current one and accepted at its end.
  task automatic send_at(input logic [7:0] b, input int k);
    repeat (k - 1) @(posedge clk);
    #1;
    bus.rx_data = b; bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'($urandom);
  endtask

  task automatic clear_mon;
    txn_q.delete(); tx_q.delete(); err_cnt = 0; viol = 0;
  endtask

  task automatic wait_tx(input int n, input int budget, input bit rnd_ready, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (tx_q.size() >= n) begin ok = 1; break; end
      if (rnd_ready) bus.tx_ready = 1'($urandom);
      tick;
    end
    if (tx_q.size() >= n) ok = 1;
  endtask

  task automatic wait_txv(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bus.tx_valid === 1'b1) ok = 1; else tick;
    end
  endtask

  task automatic test_reset;
    logic [31:0] outs;
    nrst = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
    repeat (3) tick;
    outs = {bus.tx_data, bus.tx_valid, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
            8'(bus.wb_adr_o), bus.wb_dat_o, bus.busy, bus.err};
    n_cmp++; if (outs !== 32'h0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", outs); end
    nrst = 1'b1;
    repeat (4) tick;
    n_cmp++; if (bus.busy !== 1'b0 || err_cnt !== 0) begin n_fail++; $display("FAIL reset_idle: got busy=%b errs=%0d exp 0/0", bus.busy, err_cnt); end
  endtask

  task automatic test_write;
    bit ok; txn_t t;
    clear_mon; ack_delay = 3; bus.tx_ready = 1'b1;
    send_at(8'h57, 1); send_at(8'h10, 1); send_at(8'hA5, 1);
    n_cmp++; if (bus.wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL wr_cyc_start: got %b exp 1", bus.wb_cyc_o); end
    wait_tx(1, 50, 0, ok); tick; tick;
    n_cmp++; if (!ok || txn_q.size() != 1) begin n_fail++; $display("FAIL wr_txn_count: got %0d exp 1", txn_q.size()); end
    else begin
      t = txn_q[0];
      n_cmp++; if ({t.we, t.adr, t.dat} !== {1'b1, 8'h10, 8'hA5}) begin n_fail++; $display("FAIL wr_txn: got we=%b adr=%h dat=%h exp 1/10/a5", t.we, t.adr, t.dat); end
      n_cmp++; if (t.len != 3) begin n_fail++; $display("FAIL wr_cyc_len: got %0d exp 3", t.len); end
      n_cmp++; if (tx_q[0] !== 8'h4B) begin n_fail++; $display("FAIL wr_resp: got %h exp 4b", tx_q[0]); end
    end
    n_cmp++; if (err_cnt != 0 || viol != 0) begin n_fail++; $display("FAIL wr_err_viol: got %0d/%0d exp 0/0", err_cnt, viol); end
  endtask

  task automatic test_read_hold;
    bit ok; int bad; txn_t t;
    clear_mon; ack_delay = $urandom_range(1, 5); rd_byte = 8'h3C; bus.tx_ready = 1'b0;
    send_at(8'h52, 1); send_at(8'h22, 1);
    wait_txv(40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_txv: got tx_valid=%b exp 1", bus.tx_valid); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h3C) bad++;
      tick;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rd_hold: got %0d unstable cycles exp 0", bad); end
    bus.tx_ready = 1'b1;
    wait_tx(1, 5, 0, ok); tick; tick;
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'h3C) begin n_fail++; $display("FAIL rd_resp: got n=%0d exp one 3c", tx_q.size()); end
    n_cmp++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rd_release: got tx_valid=%b busy=%b exp 0/0", bus.tx_valid, bus.busy); end
    n_cmp++; if (txn_q.size() != 1) begin n_fail++; $display("FAIL rd_txn_count: got %0d exp 1", txn_q.size()); end
    else begin
      t = txn_q[0];
      n_cmp++; if ({t.we, t.adr} !== {1'b0, exp_adr(8'h22)} || t.len != ack_delay) begin n_fail++; $display("FAIL rd_txn: got we=%b adr=%h len=%0d exp 0/%h/%0d", t.we, t.adr, t.len, exp_adr(8'h22), ack_delay); end
    end
  endtask

  task automatic test_bad_opcode;
    bit ok; logic [7:0] a; logic [7:0] b;
    clear_mon;
    send_at(8'h41, 1); repeat (3) tick;
    n_cmp++; if (err_cnt != 1 || txn_q.size() != 0 || tx_q.size() != 0) begin n_fail++; $display("FAIL bad_op: got err=%0d txn=%0d tx=%0d exp 1/0/0", err_cnt, txn_q.size(), tx_q.size()); end
    clear_mon;
    for (int i = 0; i < 3; i++) begin
      do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
      send_at(b, 1);
    end
    repeat (3) tick;
    n_cmp++; if (err_cnt != 3 || txn_q.size() != 0) begin n_fail++; $display("FAIL bad_op_burst: got err=%0d txn=%0d exp 3/0", err_cnt, txn_q.size()); end
    clear_mon; a = 8'($urandom); rd_byte = 8'($urandom); ack_delay = $urandom_range(1, 6);
    send_at(8'h52, 1); send_at(a, 1);
    wait_tx(1, 40, 0, ok); tick;
    n_cmp++; if (!ok || tx_q[0] !== rd_byte || txn_q.size() != 1 || err_cnt != 0) begin n_fail++; $display("FAIL bad_op_recover: got ok=%b tx=%h err=%0d exp 1/%h/0", ok, ok ? tx_q[0] : 8'h00, err_cnt, rd_byte); end
    else begin
      n_cmp++; if (txn_q[0].adr !== exp_adr(a)) begin n_fail++; $display("FAIL bad_op_recover_adr: got %h exp %h", txn_q[0].adr, exp_adr(a)); end
    end
  endtask

  task automatic test_frame_timeout;
    bit ok; int first; logic [7:0] a; logic [7:0] d;
    clear_mon; bus.tx_ready = 1'b1; first = 0;
    send_at(8'h57, 1); send_at(8'h10, 1);
    for (int k = 1; k <= FTO + 4; k++) begin
      @(negedge clk); if (bus.err === 1'b1 && first == 0) first = k;
      @(posedge clk); #1;
    end
    n_cmp++; if (first != FTO + 1) begin n_fail++; $display("FAIL fto_cycle: got %0d exp %0d", first, FTO + 1); end
    n_cmp++; if (err_cnt != 1 || txn_q.size() != 0 || tx_q.size() != 0) begin n_fail++; $display("FAIL fto_discard: got err=%0d txn=%0d tx=%0d exp 1/0/0", err_cnt, txn_q.size(), tx_q.size()); end
    clear_mon; rd_byte = 8'($urandom); ack_delay = 2;
    send_at(8'h52, 1); send_at(8'h22, 1);
    wait_tx(1, 40, 0, ok); tick;
    n_cmp++; if (!ok || tx_q[0] !== rd_byte || err_cnt != 0) begin n_fail++; $display("FAIL fto_next_frame: got ok=%b err=%0d exp 1/0", ok, err_cnt); end
    clear_mon; a = 8'($urandom); d = 8'($urandom);
    send_at(8'h57, 1); send_at(a, FTO); send_at(d, FTO);
    wait_tx(1, 40, 0, ok); tick;
    n_cmp++; if (!ok || tx_q[0] !== 8'h4B || err_cnt != 0 || txn_q.size() != 1) begin n_fail++; $display("FAIL fto_edge_accept: got ok=%b err=%0d txn=%0d exp 1/0/1", ok, err_cnt, txn_q.size()); end
    else begin
      n_cmp++; if ({txn_q[0].adr, txn_q[0].dat} !== {exp_adr(a), d}) begin n_fail++; $display("FAIL fto_edge_txn: got %h/%h exp %h/%h", txn_q[0].adr, txn_q[0].dat, exp_adr(a), d); end
    end
  endtask

  task automatic test_ack_timeout;
    bit ok;
    clear_mon; ack_delay = 0; bus.tx_ready = 1'b1;
    send_at(8'h52, 1); send_at(8'($urandom), 1);
    wait_tx(1, ATO + 20, 0, ok); tick;
    n_cmp++; if (!ok || tx_q[0] !== 8'h45 || err_cnt != 1) begin n_fail++; $display("FAIL ato_resp: got ok=%b err=%0d exp 1/1 with 45", ok, err_cnt); end
    n_cmp++; if (txn_q.size() != 1 || txn_q[0].len != ATO) begin n_fail++; $display("FAIL ato_len: got n=%0d exp one of %0d cycles", txn_q.size(), ATO); end
    clear_mon; ack_delay = ATO; rd_byte = 8'($urandom);
    send_at(8'h52, 1); send_at(8'($urandom), 1);
    wait_tx(1, ATO + 20, 0, ok); tick;
    n_cmp++; if (!ok || tx_q[0] !== rd_byte || err_cnt != 0) begin n_fail++; $display("FAIL ato_ack_wins: got ok=%b err=%0d exp 1/0 with %h", ok, err_cnt, rd_byte); end
  endtask

  task automatic test_reset_overrun;
    bit ok; logic [3:0] outs;
    clear_mon; ack_delay = 0; bus.tx_ready = 1'b1;
    send_at(8'h52, 1); send_at(8'($urandom), 1); repeat (3) tick;
    n_cmp++; if (bus.wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got cyc=%b exp 1", bus.wb_cyc_o); end
    #1 nrst = 1'b0;
    #1 outs = {bus.wb_cyc_o, bus.wb_stb_o, bus.tx_valid, bus.busy};
    n_cmp++; if (outs !== 4'h0) begin n_fail++; $display("FAIL rst_mid_async: got %b exp 0000", outs); end
    tick; tick; nrst = 1'b1;
    repeat (ATO + 5) tick;
    n_cmp++; if (tx_q.size() != 0 || err_cnt != 0) begin n_fail++; $display("FAIL rst_mid_silent: got tx=%0d err=%0d exp 0/0", tx_q.size(), err_cnt); end
    clear_mon; ack_delay = 2; bus.tx_ready = 1'b0;
    send_at(8'h57, 1); send_at(8'($urandom), 1); send_at(8'($urandom), 1);
    wait_txv(20, ok);
    send_at(8'h52, 1); tick;
    n_cmp++; if (!ok || err_cnt != 1 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B) begin n_fail++; $display("FAIL ovr_resp: got err=%0d txv=%b txd=%h exp 1/1/4b", err_cnt, bus.tx_valid, bus.tx_data); end
    bus.tx_ready = 1'b1; wait_tx(1, 5, 0, ok); repeat (3) tick;
    n_cmp++; if (tx_q.size() != 1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ovr_resp_drop: got tx=%0d busy=%b exp 1/0", tx_q.size(), bus.busy); end
    clear_mon; ack_delay = 8; rd_byte = 8'($urandom);
    send_at(8'h52, 1); send_at(8'($urandom), 1); send_at(8'h57, 2);
    wait_tx(1, 40, 0, ok); tick;
    n_cmp++; if (!ok || tx_q[0] !== rd_byte || err_cnt != 1 || txn_q.size() != 1) begin n_fail++; $display("FAIL ovr_bus: got ok=%b err=%0d txn=%0d exp 1/1/1", ok, err_cnt, txn_q.size()); end
  endtask

  task automatic test_back_to_back;
    bit ok; bit we; logic [7:0] a, d, rd, er; int dly; txn_t t;
    stray_en = 1;
    for (int f = 0; f < 40; f++) begin
      clear_mon; bus.tx_ready = 1'b0;
      we = 1'($urandom); a = 8'($urandom); d = 8'($urandom); rd = 8'($urandom);
      dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      ack_delay = dly; rd_byte = rd;
      send_at(we ? 8'h57 : 8'h52, $urandom_range(1, 4));
      send_at(a, $urandom_range(1, FTO));
      if (we) send_at(d, $urandom_range(1, FTO));
      wait_tx(1, 300, 1, ok); tick;
      er = exp_rsp(we, dly, rd);
      n_cmp++; if (!ok || tx_q.size() != 1 || tx_q[0] !== er) begin n_fail++; $display("FAIL b2b_resp[%0d]: got n=%0d exp %h", f, tx_q.size(), er); end
      n_cmp++; if (err_cnt != (dly == 0 ? 1 : 0)) begin n_fail++; $display("FAIL b2b_err[%0d]: got %0d exp %0d", f, err_cnt, dly == 0 ? 1 : 0); end
      n_cmp++; if (txn_q.size() != 1) begin n_fail++; $display("FAIL b2b_txn_count[%0d]: got %0d exp 1", f, txn_q.size()); end
      else begin
        t = txn_q[0];
        n_cmp++; if (t.we !== we || t.adr !== exp_adr(a) || (we && t.dat !== d)) begin n_fail++; $display("FAIL b2b_txn[%0d]: got %b/%h/%h exp %b/%h/%h", f, t.we, t.adr, t.dat, we, exp_adr(a), d); end
        n_cmp++; if (t.len != (dly == 0 ? ATO : dly)) begin n_fail++; $display("FAIL b2b_len[%0d]: got %0d exp %0d", f, t.len, dly == 0 ? ATO : dly); end
      end
      n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL b2b_stability[%0d]: got %0d exp 0", f, viol); end
    end
    stray_en = 0;
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
    test_reset;
    test_write;
    test_read_hold;
    test_bad_opcode;
    test_frame_timeout;
    test_ack_timeout;
    test_reset_overrun;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
